// File: rtl/seed_pkg.sv
// Shared types, default sizes and address helper for the seed memory reader.
package seed_pkg;

    localparam int SEED_DEPTH  = 2500;
    localparam int SEED_ADDR_W = 12;
    localparam int SEED_DATA_W = 32;
    localparam logic [SEED_DATA_W-1:0] SEED_ZERO_SUB = 32'h0000_0001;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DRAIN,
        ST_DONE
    } state_t;

    // Next word address, wrapping from depth-1 back to 0.
    function automatic logic [SEED_ADDR_W-1:0] mod_inc(
        input logic [SEED_ADDR_W-1:0] addr,
        input logic [SEED_ADDR_W-1:0] depth
    );
        return (addr == depth - 1'b1) ? '0 : addr + 1'b1;
    endfunction

endpackage

// File: rtl/seed_skid_fifo.sv
// Purpose: 2-entry FIFO holding returned seeds (data plus last flag).
// Latency: 1 cycle push-to-head; head is visible directly on pop_dat_o.
// Backpressure: push while full is accepted only together with a pop.
module seed_skid_fifo #(
    parameter int W = 33
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push_i,
    input  logic [W-1:0] push_dat_i,
    input  logic         pop_i,
    output logic [W-1:0] pop_dat_o,
    output logic         full_o,
    output logic         empty_o,
    output logic [1:0]   count_o
);

    logic [W-1:0] mem_q [2];
    logic         wr_ptr_q;
    logic         rd_ptr_q;
    logic [1:0]   cnt_q;
    logic         do_push;
    logic         do_pop;

    assign do_pop  = pop_i && (cnt_q != 2'd0);
    assign do_push = push_i && ((cnt_q != 2'd2) || do_pop);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_dat_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            cnt_q <= cnt_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    assign pop_dat_o = mem_q[rd_ptr_q];
    assign full_o    = (cnt_q == 2'd2);
    assign empty_o   = (cnt_q == 2'd0);
    assign count_o   = cnt_q;

endmodule

// File: rtl/seed_stream_reader.sv
// Purpose: drains count seed words from base (wrapping at DEPTH) into a valid/ready stream.
// Latency: first seed_valid 3 cycles after start; one seed per clock with ready held high.
// Backpressure: reads issue only while buffered + in-flight words leave room in the 2-entry FIFO.
module seed_stream_reader
    import seed_pkg::*;
#(
    parameter int DEPTH  = SEED_DEPTH,
    parameter int ADDR_W = SEED_ADDR_W,
    parameter int DATA_W = SEED_DATA_W,
    parameter logic [DATA_W-1:0] ZERO_SUB = SEED_ZERO_SUB
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] count,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [3:0]        mem_byteenable,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata,
    output logic [DATA_W-1:0] seed_data,
    output logic              seed_valid,
    input  logic              seed_ready,
    output logic              seed_last,
    output logic              busy,
    output logic              done,
    output logic              err_base,
    output logic [ADDR_W-1:0] zero_cnt
);

    localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

    state_t            state_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] cnt_q;
    logic [ADDR_W-1:0] issued_q;
    logic [ADDR_W-1:0] push_idx_q;
    logic [ADDR_W-1:0] zero_cnt_q;
    logic              inflight_q;
    logic              busy_q;
    logic              done_q;
    logic              err_q;

    logic              fifo_full;
    logic              fifo_empty;
    logic [1:0]        fifo_cnt;
    logic [DATA_W:0]   head_dat;
    logic [DATA_W:0]   push_dat;
    logic              pop;
    logic              credit_ok;
    logic              issue_d;
    logic              rd_zero;
    logic              push_last;

    assign pop = !fifo_empty && seed_ready;

    // Counting this cycle's pop lets a read issue into the slot being freed,
    // which is what sustains one seed per clock through a 2-deep buffer.
    always_comb begin
        credit_ok = 1'b0;
        if (fifo_full) begin
            credit_ok = pop && !inflight_q;
        end else begin
            credit_ok = ({1'b0, fifo_cnt} + {2'b0, inflight_q}) < (3'd2 + {2'b0, pop});
        end
    end

    assign issue_d   = (state_q == ST_FETCH) && (issued_q < cnt_q) && credit_ok;
    assign rd_zero   = (mem_readdata == '0);
    assign push_last = (push_idx_q == cnt_q - 1'b1);
    assign push_dat  = {push_last, rd_zero ? ZERO_SUB : mem_readdata};

    seed_skid_fifo #(
        .W (DATA_W + 1)
    ) u_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .push_i     (inflight_q),
        .push_dat_i (push_dat),
        .pop_i      (pop),
        .pop_dat_o  (head_dat),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .count_o    (fifo_cnt)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            cnt_q      <= '0;
            issued_q   <= '0;
            push_idx_q <= '0;
            zero_cnt_q <= '0;
            inflight_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            inflight_q <= issue_d;
            if (issue_d) begin
                addr_q   <= mod_inc(addr_q, DEPTH_A);
                issued_q <= issued_q + 1'b1;
            end
            if (inflight_q) begin
                push_idx_q <= push_idx_q + 1'b1;
                if (rd_zero && (zero_cnt_q != '1)) begin
                    zero_cnt_q <= zero_cnt_q + 1'b1;
                end
            end
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (base_addr >= DEPTH_A) begin
                            err_q <= 1'b1;
                        end else if (count == '0) begin
                            zero_cnt_q <= '0;
                            done_q     <= 1'b1;
                            state_q    <= ST_DONE;
                        end else begin
                            addr_q     <= base_addr;
                            cnt_q      <= count;
                            issued_q   <= '0;
                            push_idx_q <= '0;
                            zero_cnt_q <= '0;
                            busy_q     <= 1'b1;
                            state_q    <= ST_FETCH;
                        end
                    end
                end
                ST_FETCH: begin
                    if (issue_d && (issued_q + 1'b1 == cnt_q)) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (fifo_empty && !inflight_q) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_address    = addr_q;
    assign mem_chipselect = issue_d;
    assign mem_write      = 1'b0;
    assign mem_byteenable = 4'hF;
    assign mem_clken      = 1'b1;
    assign seed_valid     = !fifo_empty;
    assign seed_data      = head_dat[DATA_W-1:0];
    assign seed_last      = head_dat[DATA_W] && !fifo_empty;
    assign busy           = busy_q;
    assign done           = done_q;
    assign err_base       = err_q;
    assign zero_cnt       = zero_cnt_q;

endmodule
